// File: rtl/fir_host_seq_pkg.sv
// Shared types and constants for the FIR host-side sequencer.
package fir_host_pkg;
    localparam int NUM_TAPS_DEF = 10;
    localparam int GUARD_DEF    = 5;
    localparam int BANK_W       = 2;
    localparam int TAP_W        = 4;
    localparam logic [TAP_W-1:0] TAIL_TAP = 4'hB;

    typedef enum logic [2:0] {
        IDLE,
        LD_FLAG,
        LD_WR,
        LD_GUARD,
        RD_FLAG,
        RD_ADDR,
        RD_TAIL
    } state_t;
endpackage

// File: rtl/fir_host_seq_if.sv
// Control bus between the host sequencer (master) and the system/FIR side (slave).
interface fir_host_seq_if #(parameter int DATA_W = 16);
    logic              iEnSample600k;
    logic              iRunEn;
    logic [1:0]        iRunBank;
    logic [2:0]        iSample;
    logic              iLoadReq;
    logic [1:0]        iLoadBank;
    logic [3:0]        oCoefAddr;
    logic [DATA_W-1:0] iCoefData;
    logic              oCoeffUpdateFlag;
    logic              oMemRdFlag;
    logic [5:0]        oAddrRam;
    logic [DATA_W-1:0] oWtDtRam;
    logic [2:0]        oFirIn;
    logic              oBusy;
    logic              oLoadDone;
    logic              oSampleMiss;

    modport master (
        input  iEnSample600k, iRunEn, iRunBank, iSample, iLoadReq, iLoadBank, iCoefData,
        output oCoefAddr, oCoeffUpdateFlag, oMemRdFlag, oAddrRam, oWtDtRam, oFirIn,
               oBusy, oLoadDone, oSampleMiss
    );

    modport slave (
        output iEnSample600k, iRunEn, iRunBank, iSample, iLoadReq, iLoadBank, iCoefData,
        input  oCoefAddr, oCoeffUpdateFlag, oMemRdFlag, oAddrRam, oWtDtRam, oFirIn,
               oBusy, oLoadDone, oSampleMiss
    );
endinterface

// File: rtl/fir_host_seq_tap_counter.sv
// Saturating up-counter with synchronous clear; tc_o flags cnt_o == last_i.
module fir_tap_counter
    import fir_host_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [TAP_W-1:0] last_i,
    output logic [TAP_W-1:0] cnt_o,
    output logic             tc_o
);
    logic [TAP_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);
endmodule

// File: rtl/fir_host_seq.sv
// Host sequencer: coefficient bank loads and per-sample read passes for the FIR.
// state    | meaning
// IDLE     | arbitrate: enabled strobe first, then pending load
// LD_FLAG  | raise update flag, present coef address 0
// LD_WR    | write one tap per cycle from the coefficient source
// LD_GUARD | tail write, then hold for GUARD cycles, pulse done
// RD_FLAG  | raise read flag with the captured sample
// RD_ADDR  | step tap addresses of the latched bank
// RD_TAIL  | drop read flag, park address at tap 0
module fir_host_seq
    import fir_host_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_DEF,
    parameter int GUARD    = GUARD_DEF,
    parameter int DATA_W   = 16
) (
    input  logic           iClk12M,
    input  logic           iRsn,
    fir_host_seq_if.master bus
);
    state_t            state_q;
    logic [BANK_W-1:0] bank_q, pend_bank_q;
    logic              pend_q;
    logic [2:0]        sample_q;
    logic [TAP_W-1:0]  coef_addr_q;
    logic              upd_q, rd_q, busy_q, done_q, miss_q;
    logic [5:0]        addr_q;
    logic [DATA_W-1:0] wt_q;
    logic [2:0]        fir_q;

    logic              strobe_en;
    logic              cnt_clr, cnt_en, tap_tc;
    logic [TAP_W-1:0]  cnt_last, tap;

    assign strobe_en = bus.iEnSample600k & bus.iRunEn;

    // One counter serves tap stepping and the guard interval; cleared between uses.
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        cnt_last = TAP_W'(NUM_TAPS - 1);
        unique case (state_q)
            LD_WR:    if (tap_tc) cnt_clr = 1'b1; else cnt_en = 1'b1;
            LD_GUARD: begin cnt_en = 1'b1; cnt_last = TAP_W'(GUARD); end
            RD_ADDR:  cnt_en = 1'b1;
            default:  cnt_clr = 1'b1;
        endcase
    end

    fir_tap_counter u_tap_cnt (
        .clk    (iClk12M),
        .rst_n  (iRsn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .last_i (cnt_last),
        .cnt_o  (tap),
        .tc_o   (tap_tc)
    );

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            pend_bank_q <= '0;
            pend_q      <= 1'b0;
            sample_q    <= '0;
            coef_addr_q <= '0;
            upd_q       <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            miss_q      <= 1'b0;
            addr_q      <= '0;
            wt_q        <= '0;
            fir_q       <= '0;
        end else begin
            done_q <= 1'b0;
            miss_q <= strobe_en && (state_q != IDLE);

            // A new request always lands in the pending slot, even on the edge a load starts.
            if (bus.iLoadReq) begin
                pend_q      <= 1'b1;
                pend_bank_q <= bus.iLoadBank;
            end else if (state_q == IDLE && !strobe_en && pend_q) begin
                pend_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (strobe_en) begin
                        state_q  <= RD_FLAG;
                        bank_q   <= bus.iRunBank;
                        sample_q <= bus.iSample;
                        busy_q   <= 1'b1;
                    end else if (pend_q) begin
                        state_q <= LD_FLAG;
                        bank_q  <= pend_bank_q;
                        busy_q  <= 1'b1;
                    end
                end
                LD_FLAG: begin
                    upd_q       <= 1'b1;
                    coef_addr_q <= '0;
                    state_q     <= LD_WR;
                end
                LD_WR: begin
                    addr_q      <= {bank_q, tap};
                    wt_q        <= bus.iCoefData;
                    coef_addr_q <= tap_tc ? tap : tap + 4'd1;
                    if (tap_tc) state_q <= LD_GUARD;
                end
                LD_GUARD: begin
                    if (tap == '0) begin
                        upd_q  <= 1'b0;
                        addr_q <= {bank_q, TAIL_TAP};
                        wt_q   <= '0;
                    end
                    if (tap_tc) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RD_FLAG: begin
                    rd_q    <= 1'b1;
                    fir_q   <= sample_q;
                    state_q <= RD_ADDR;
                end
                RD_ADDR: begin
                    addr_q <= {bank_q, tap};
                    fir_q  <= '0;
                    if (tap_tc) state_q <= RD_TAIL;
                end
                RD_TAIL: begin
                    rd_q    <= 1'b0;
                    addr_q  <= {bank_q, 4'h0};
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oCoefAddr        = coef_addr_q;
    assign bus.oCoeffUpdateFlag = upd_q;
    assign bus.oMemRdFlag       = rd_q;
    assign bus.oAddrRam         = addr_q;
    assign bus.oWtDtRam         = wt_q;
    assign bus.oFirIn           = fir_q;
    assign bus.oBusy            = busy_q;
    assign bus.oLoadDone        = done_q;
    assign bus.oSampleMiss      = miss_q;
endmodule
